nios2_avalon_st_fifo_arbiter: RTL



---
 rtl/nios2_avalon_st_arb_pkg.sv | 30 +++
 rtl/nios2_avalon_st_rr_picker.sv | 48 ++++
 rtl/nios2_avalon_st_fifo_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/nios2_avalon_st_arb_pkg.sv
// -----------------------------------------------------------------------------
// nios2_avalon_st_arb_pkg
// Shared types and helpers for the Avalon-ST FIFO write-side arbiter.
//   arb_state_e  : arbiter FSM states (IDLE between grants, BURST while owned)
//   clog2        : ceiling log2, usable in parameter/port width expressions
//   GRANT_WIDTH  : grant index width for the default four-source build
// -----------------------------------------------------------------------------
package nios2_avalon_st_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int GRANT_WIDTH     = clog2(DEFAULT_NUM_REQ);

endpackage

// File: rtl/nios2_avalon_st_rr_picker.sv
// -----------------------------------------------------------------------------
// nios2_avalon_st_rr_picker
// Combinational round-robin priority search. The search starts one past
// rr_ptr and wraps, so the index held in rr_ptr (the previous owner) has
// the lowest priority.
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  GW       index of the most recent owner
//   winner  out GW       first requesting index after rr_ptr (0 when none)
//   any_req out 1        at least one request bit is set
// -----------------------------------------------------------------------------
module nios2_avalon_st_rr_picker
  import nios2_avalon_st_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int GW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic [GW-1:0]      winner,
  output logic               any_req
);

  // (base + offset) mod NUM_REQ, done in int so non-power-of-two counts wrap.
  function automatic logic [GW-1:0] next_index(input logic [GW-1:0] base,
                                               input int offset);
    int sum;
    sum = int'(base) + offset;
    return GW'(sum % NUM_REQ);
  endfunction

  logic [GW-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = next_index(rr_ptr, k);
      if (!any_req && req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios2_avalon_st_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// nios2_avalon_st_fifo_arbiter
// Round-robin, burst-limited arbiter sharing the write port of the Avalon-ST
// timing-adapter FIFO between NUM_REQ sources. A grant is only issued below
// the high watermark; the owner then streams straight through (zero latency)
// until its burst limit, it goes idle, or the FIFO nears full.
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_data    per-source stream in (source i at [i*DATA_WIDTH +:])
//   req_ready             per-source ready, only the owner's bit can be high
//   fifo_valid/fifo_data  to FIFO in_valid / in_data
//   fifo_ready            from FIFO in_ready
//   fill_level            from FIFO fill_level (0..16)
//   grant                 index of the current owner
//   busy                  high while a burst is in progress
// -----------------------------------------------------------------------------
module nios2_avalon_st_fifo_arbiter
  import nios2_avalon_st_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 42,
  parameter int FILL_WIDTH     = 5,
  parameter int HIGH_WATERMARK = 14,
  parameter int MAX_BURST      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_valid,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_ready,
  input  logic [FILL_WIDTH-1:0]         fill_level,
  output logic [clog2(NUM_REQ)-1:0]     grant,
  output logic                          busy
);

  localparam int GW = clog2(NUM_REQ);
  localparam int CW = clog2(MAX_BURST + 1);
  localparam int LW = FILL_WIDTH + 1;

  localparam logic [LW-1:0] HWM      = LW'(HIGH_WATERMARK);
  localparam logic [CW-1:0] MAXB     = CW'(MAX_BURST);
  localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [LW-1:0] fill_ext, fill_inc;
  logic [CW-1:0] beat_cnt_inc;
  logic          below_hwm, owner_valid, beat, exit_burst;
  logic [GW-1:0] winner;
  logic          any_req;

  // One extra bit so fill_level+1 cannot wrap and full (16) compares high.
  assign fill_ext     = {1'b0, fill_level};
  assign fill_inc     = fill_ext + LW'(1);
  assign below_hwm    = fill_ext < HWM;
  assign beat_cnt_inc = beat_cnt_q + CW'(1);
  assign owner_valid  = req_valid[grant_q];

  nios2_avalon_st_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Zero-latency passthrough from the owner; handshakes are held off while
  // reset is high so a reset cycle can never complete a beat.
  always_comb begin
    req_ready  = '0;
    fifo_valid = 1'b0;
    fifo_data  = '0;
    if (state_q == BURST) begin
      fifo_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      if (!reset) begin
        fifo_valid         = owner_valid;
        req_ready[grant_q] = fifo_ready;
      end
    end
  end

  assign beat = fifo_valid && fifo_ready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    exit_burst = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req && below_hwm) begin
          state_d    = BURST;
          grant_d    = winner;
          rr_ptr_d   = winner;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_inc;
        end
        // Burst limit, owner idle, last beat reaching the watermark, or a
        // stall against a FIFO that is already at the watermark.
        exit_burst = (beat && (beat_cnt_inc == MAXB))
                   || !owner_valid
                   || (beat && (fill_inc >= HWM))
                   || (!fifo_ready && !below_hwm);
        if (exit_burst) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= LAST_REQ;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BURST);

endmodule
